dmem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer placed in front of the 64-byte, byte-addressed, doubleword-wide data memory. Port 0 serves the pipeline MEM stage, port 1 serves the test/debug loader. It grants one requester at a time, drives the single memory port for exactly one cycle per access, captures read data, and range-checks every address before the memory sees it.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 25 ++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Data memory geometry
    localparam int MEM_BYTES   = 64;
    localparam int DWORD_BYTES = 8;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational 2-way round-robin picker. The pointer
//                (last_served) is owned by the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] grant
);

    // A lone requester always wins; on a tie the port not served last wins.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = last_served ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-requester arbiter and one-cycle access sequencer in
//                front of the doubleword-wide data memory, with address
//                range checking and a registered read-data return.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Highest legal doubleword start address, compared at full width so
    // that addresses near the top of the space cannot wrap into range.
    localparam logic [ADDR_W-1:0] C_MAX_ADDR = ADDR_W'(MEM_BYTES - DWORD_BYTES);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_last_served;
    logic                r_port;
    logic                r_we;
    logic                r_legal;
    logic [1:0]          r_gnt;
    logic [1:0]          r_done;
    logic [1:0]          r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    logic                w_win_port;
    logic                w_win_we;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic                w_win_legal;
    logic [1:0]          w_port_oh;

    assign w_req = {req1, req0};

    rr_arb2 u_rr_arb2 (
        .req         (w_req),
        .last_served (r_last_served),
        .grant       (w_grant)
    );

    // Winner mux and range check, evaluated in IDLE
    assign w_win_port  = w_grant[1];
    assign w_win_we    = w_win_port ? we1    : we0;
    assign w_win_addr  = w_win_port ? addr1  : addr0;
    assign w_win_wdata = w_win_port ? wdata1 : wdata0;
    assign w_win_legal = (w_win_addr <= C_MAX_ADDR);
    assign w_port_oh   = r_port ? 2'b10 : 2'b01;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one grant, one memory cycle, one response cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_state_next = ACCESS;
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Request latch, round-robin pointer, response pulses and read data.
    // mem_addr/mem_wdata are only reloaded for legal accesses so the memory
    // port holds its last value otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_served <= 1'b1;
            r_port        <= 1'b0;
            r_we          <= 1'b0;
            r_legal       <= 1'b0;
            r_gnt         <= 2'b00;
            r_done        <= 2'b00;
            r_err         <= 2'b00;
            r_rdata       <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_gnt  <= 2'b00;
            r_done <= 2'b00;
            r_err  <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_gnt         <= w_grant;
                        r_last_served <= w_win_port;
                        r_port        <= w_win_port;
                        r_we          <= w_win_we;
                        r_legal       <= w_win_legal;
                        if (w_win_legal) begin
                            r_mem_addr  <= w_win_addr;
                            r_mem_wdata <= w_win_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (r_legal && !r_we) begin
                        r_rdata <= mem_rdata;
                    end
                    r_done <= w_port_oh;
                    r_err  <= r_legal ? 2'b00 : w_port_oh;
                end
                default: ;
            endcase
        end
    end

    // Memory strobes: only in ACCESS for legal accesses, and killed by reset
    // within the same cycle.
    assign mem_write = (r_state == ACCESS) && r_legal &&  r_we && !reset;
    assign mem_read  = (r_state == ACCESS) && r_legal && !r_we && !reset;

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;
    assign gnt0      = r_gnt[0];
    assign gnt1      = r_gnt[1];
    assign done0     = r_done[0];
    assign done1     = r_done[1];
    assign err0      = r_err[0];
    assign err1      = r_err[1];

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a
//                behavioural 8-doubleword memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [63:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    int passed = 0;
    int total  = 0;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .err0      (err0),
        .err1      (err1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural memory: 8 doublewords, synchronous write, combinational read
    logic [63:0] mem [0:7] = '{default: '0};
    always @(posedge clk) if (mem_write) mem[mem_addr[5:3]] <= mem_wdata;
    assign mem_rdata = mem_read ? mem[mem_addr[5:3]] : 64'h0;

    // Strobe / response activity counters
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
    always @(posedge clk) begin
        if (mem_write)      wr_cnt   <= wr_cnt + 1;
        if (mem_read)       rd_cnt   <= rd_cnt + 1;
        if (done0 || done1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full access on one port; returns what was observed at each stage.
    task automatic access(input int port, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic g, output logic wr,
                          output logic rd, output logic d, output logic e,
                          output logic [63:0] rdat);
        if (port == 0) begin
            we0 = we; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
        end else begin
            we1 = we; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
        end
        tick();
        g  = (port == 0) ? gnt0 : gnt1;
        wr = mem_write;
        rd = mem_read;
        tick();
        d    = (port == 0) ? done0 : done1;
        e    = (port == 0) ? err0  : err1;
        rdat = rdata;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick();
        tick();
        total++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {gnt0, gnt1}); else passed++;
        total++; if ({done0, done1, err0, err1} !== 4'b0) $display("FAIL reset_done_err: got %b want 0000", {done0, done1, err0, err1}); else passed++;
        total++; if ({mem_write, mem_read} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {mem_write, mem_read}); else passed++;
        total++; if (mem_addr !== 64'h0 || mem_wdata !== 64'h0) $display("FAIL reset_mem_port: got addr %h wdata %h want 0", mem_addr, mem_wdata); else passed++;
        total++; if (rdata !== 64'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        logic g, wr, rd, d, e;
        logic [63:0] rv;
        int w0;
        w0 = wr_cnt;
        access(0, 1'b1, 64'd8, 64'h1122_3344_5566_7788, g, wr, rd, d, e, rv);
        total++; if (g !== 1'b1) $display("FAIL wr_gnt0: got %b want 1", g); else passed++;
        total++; if (wr !== 1'b1 || rd !== 1'b0) $display("FAIL wr_strobe: got w%b r%b want w1 r0", wr, rd); else passed++;
        total++; if (wr_cnt - w0 !== 1) $display("FAIL wr_strobe_len: got %0d want 1", wr_cnt - w0); else passed++;
        total++; if (d !== 1'b1 || e !== 1'b0) $display("FAIL wr_done: got done %b err %b want 1 0", d, e); else passed++;
        total++; if (mem_addr !== 64'd8) $display("FAIL wr_mem_addr: got %h want 8", mem_addr); else passed++;
        access(0, 1'b0, 64'd8, 64'h0, g, wr, rd, d, e, rv);
        total++; if (rd !== 1'b1 || wr !== 1'b0) $display("FAIL rd_strobe: got w%b r%b want w0 r1", wr, rd); else passed++;
        total++; if (d !== 1'b1 || e !== 1'b0) $display("FAIL rd_done: got done %b err %b want 1 0", d, e); else passed++;
        total++; if (rv !== 64'h1122_3344_5566_7788) $display("FAIL rd_data: got %h want 1122334455667788", rv); else passed++;
    endtask

    task automatic test_tie();
        logic exp1;
        reset = 1'b1; req0 = 0; req1 = 0;
        tick();
        reset = 1'b0;
        we0 = 0; we1 = 0; addr0 = 64'd0; addr1 = 64'd8;
        req0 = 1; req1 = 1;
        for (int s = 0; s < 4; s++) begin
            exp1 = (s % 2 == 1);
            tick();
            total++; if ({gnt1, gnt0} !== {exp1, ~exp1}) $display("FAIL tie_gnt_slot%0d: got %b want %b", s, {gnt1, gnt0}, {exp1, ~exp1}); else passed++;
            tick();
            total++; if ({done1, done0} !== {exp1, ~exp1}) $display("FAIL tie_done_slot%0d: got %b want %b", s, {done1, done0}, {exp1, ~exp1}); else passed++;
            if (s == 3) begin
                req0 = 0; req1 = 0;
            end
            tick();
        end
    endtask

    task automatic test_port1_reads();
        logic [63:0] exp_rd [0:3];
        exp_rd[0] = 64'h0; exp_rd[1] = 64'h1122_3344_5566_7788;
        exp_rd[2] = 64'h0; exp_rd[3] = 64'h0;
        we1 = 0; req1 = 1;
        for (int s = 0; s < 4; s++) begin
            addr1 = 64'(s * 8);
            tick();
            total++; if ({gnt1, gnt0} !== 2'b10) $display("FAIL p1_gnt_slot%0d: got %b want 10", s, {gnt1, gnt0}); else passed++;
            tick();
            total++; if ({done1, done0} !== 2'b10 || rdata !== exp_rd[s]) $display("FAIL p1_rd_slot%0d: got done %b data %h want 10 %h", s, {done1, done0}, rdata, exp_rd[s]); else passed++;
            if (s == 3) req1 = 0;
            tick();
        end
    endtask

    task automatic test_range();
        logic g, wr, rd, d, e;
        logic [63:0] rv;
        int w0, r0;
        access(0, 1'b1, 64'd56, 64'hA5A5_A5A5_5A5A_5A5A, g, wr, rd, d, e, rv);
        total++; if (d !== 1'b1 || e !== 1'b0) $display("FAIL rng_56_wr: got done %b err %b want 1 0", d, e); else passed++;
        w0 = wr_cnt; r0 = rd_cnt;
        access(0, 1'b1, 64'd57, 64'hFFFF_0000_FFFF_0000, g, wr, rd, d, e, rv);
        total++; if (d !== 1'b1 || e !== 1'b1) $display("FAIL rng_57_err: got done %b err %b want 1 1", d, e); else passed++;
        total++; if (mem_addr !== 64'd56) $display("FAIL rng_57_addr_hold: got %h want 38", mem_addr); else passed++;
        access(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1234_0000_0000_4321, g, wr, rd, d, e, rv);
        total++; if (d !== 1'b1 || e !== 1'b1) $display("FAIL rng_top_err: got done %b err %b want 1 1", d, e); else passed++;
        access(0, 1'b0, 64'd57, 64'h0, g, wr, rd, d, e, rv);
        total++; if (e !== 1'b1 || rv !== 64'h0) $display("FAIL rng_57_rd: got err %b data %h want 1 0", e, rv); else passed++;
        total++; if (wr_cnt !== w0 || rd_cnt !== r0) $display("FAIL rng_no_strobe: got %0d writes %0d reads want 0 0", wr_cnt - w0, rd_cnt - r0); else passed++;
        access(0, 1'b0, 64'd56, 64'h0, g, wr, rd, d, e, rv);
        total++; if (e !== 1'b0 || rv !== 64'hA5A5_A5A5_5A5A_5A5A) $display("FAIL rng_56_rd: got err %b data %h want 0 a5a5a5a55a5a5a5a", e, rv); else passed++;
    endtask

    task automatic test_reset_mid_access();
        logic g, wr, rd, d, e;
        logic [63:0] rv;
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        we0 = 1; addr0 = 64'd0; wdata0 = 64'hDEAD_BEEF_DEAD_BEEF; req0 = 1;
        tick();
        total++; if (gnt0 !== 1'b1) $display("FAIL rst_mid_gnt: got %b want 1", gnt0); else passed++;
        reset = 1'b1; req0 = 0;
        #1;
        total++; if (mem_write !== 1'b0) $display("FAIL rst_mid_strobe: got %b want 0", mem_write); else passed++;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        total++; if (wr_cnt !== w0 || done_cnt !== d0) $display("FAIL rst_mid_quiet: got %0d writes %0d dones want 0 0", wr_cnt - w0, done_cnt - d0); else passed++;
        access(0, 1'b0, 64'd0, 64'h0, g, wr, rd, d, e, rv);
        total++; if (d !== 1'b1 || rv !== 64'h0) $display("FAIL rst_mid_rd0: got done %b data %h want 1 0", d, rv); else passed++;
    endtask

    task automatic test_back_to_back();
        logic g, wr, rd, d, e;
        logic [63:0] rv;
        access(0, 1'b1, 64'd16, 64'h0BAD_F00D_CAFE_BEEF, g, wr, rd, d, e, rv);
        total++; if (d !== 1'b1 || e !== 1'b0) $display("FAIL b2b_wr: got done %b err %b want 1 0", d, e); else passed++;
        access(1, 1'b0, 64'd16, 64'h0, g, wr, rd, d, e, rv);
        total++; if (g !== 1'b1 || d !== 1'b1) $display("FAIL b2b_p1_handshake: got gnt %b done %b want 1 1", g, d); else passed++;
        total++; if (rv !== 64'h0BAD_F00D_CAFE_BEEF) $display("FAIL b2b_rdata: got %h want 0badf00dcafebeef", rv); else passed++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_port1_reads();
        test_range();
        test_reset_mid_access();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
